// File: rtl/or3_lab_pkg.sv
// Shared types and the reference function for the gate-lab sequencers.
// Swapping expected_or3 is all a different gate lab needs.
package or3_lab_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NUM_VECTORS = 8;
    localparam int VEC_W       = 3;

    function automatic logic expected_or3(input logic [VEC_W-1:0] vec);
        return |vec;
    endfunction

endpackage

// File: rtl/or3_vector_sequencer_if.sv
// Stimulus/result bundle between the sequencer and whatever drives start and the gate.
interface or3_vector_sequencer_if;
    import or3_lab_pkg::*;

    logic             start;
    logic [VEC_W-1:0] abc;
    logic             d;
    logic             busy;
    logic             done;
    logic             pass;
    logic [3:0]       err_count;
    logic [7:0]       err_mask;

    modport master (
        output start, d,
        input  abc, busy, done, pass, err_count, err_mask
    );

    modport slave (
        input  start, d,
        output abc, busy, done, pass, err_count, err_mask
    );
endinterface

// File: rtl/dwell_timer.sv
// Counts the cycles a vector is held; last flags the final cycle of each dwell.
module dwell_timer #(
    parameter int DWELL = 20,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;

    assign last = (cnt_q == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/or3_vector_sequencer.sv
// Walks a 3-input OR gate through all 8 vectors, holds each for DWELL cycles,
// and records which vectors produced a wrong output.
module or3_vector_sequencer
    import or3_lab_pkg::*;
#(
    parameter int DWELL = 20,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    or3_vector_sequencer_if.slave bus
);

    if (DWELL < 2 || DWELL > 65535 || (64'(1) << CNT_W) < 64'(DWELL)) begin : g_bad_params
        $error("or3_vector_sequencer: DWELL must be 2..65535 and fit in CNT_W bits");
    end

    state_e           state_q;
    logic [VEC_W-1:0] vec_q;
    logic [VEC_W-1:0] abc_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [3:0]       err_count_q;
    logic [7:0]       err_mask_q;

    logic       last;
    logic       running;
    logic       mismatch;
    logic       sample;
    logic [3:0] err_count_d;
    logic [7:0] err_mask_d;

    assign running = (state_q == RUN);

    dwell_timer #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!running),
        .enable (running),
        .last   (last)
    );

    // Case inequality so an undriven or X gate output counts as a failure.
    assign mismatch    = (bus.d !== expected_or3(vec_q));
    assign sample      = running && last;
    assign err_count_d = err_count_q + {3'b000, sample && mismatch};

    for (genvar gi = 0; gi < NUM_VECTORS; gi++) begin : g_mask
        assign err_mask_d[gi] = err_mask_q[gi] | (sample && mismatch && (vec_q == VEC_W'(gi)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            abc_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            err_mask_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q     <= RUN;
                        vec_q       <= '0;
                        abc_q       <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        err_count_q <= '0;
                        err_mask_q  <= '0;
                    end
                end
                RUN: begin
                    err_count_q <= err_count_d;
                    err_mask_q  <= err_mask_d;
                    if (last) begin
                        if (vec_q == VEC_W'(NUM_VECTORS - 1)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_count_d == 4'd0);
                        end else begin
                            vec_q <= vec_q + VEC_W'(1);
                            abc_q <= vec_q + VEC_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.abc       = abc_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_count_q;
    assign bus.err_mask  = err_mask_q;

endmodule

// File: tb/tb_or3_vector_sequencer.sv
// Drives two sequencers (DWELL=20 and DWELL=2) against a modelled gate with
// selectable faults and checks outputs cycle by cycle.
module tb_or3_vector_sequencer;

    localparam int D20 = 20;
    localparam int D2  = 2;

    logic clk = 1'b0;
    logic rst20, rst2;
    int   errors = 0;
    int   checks = 0;

    int       mode20 = 0, mode2 = 0;
    logic [7:0] flip20 = 8'h00, flip2 = 8'h00;

    always #5 clk = ~clk;

    or3_vector_sequencer_if b20();
    or3_vector_sequencer_if b2();

    or3_vector_sequencer #(.DWELL(D20), .CNT_W(16)) dut20 (.clk(clk), .rst(rst20), .bus(b20));
    or3_vector_sequencer #(.DWELL(D2),  .CNT_W(4))  dut2  (.clk(clk), .rst(rst2),  .bus(b2));

    // Gate under test: 0 good, 1 stuck-0, 2 stuck-1, 3 a-only, 4 good^flip[v], 5 X on vector 5
    function automatic logic gate(input logic [2:0] v, input int mode, input logic [7:0] flip);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return v[2];
            4:       return (v != 3'd0) ^ flip[v];
            5:       return (v == 3'd5) ? 1'bx : (v != 3'd0);
            default: return (v != 3'd0);
        endcase
    endfunction

    assign b20.d = gate(b20.abc, mode20, flip20);
    assign b2.d  = gate(b2.abc, mode2, flip2);

    function automatic logic [7:0] ref_mask(input int mode, input logic [7:0] flip);
        logic [7:0] m = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (gate(3'(k), mode, flip) !== (k != 0)) m[k] = 1'b1;
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_done20(input logic [7:0] exp_mask);
        check("done20_flags", {b20.busy, b20.done, b20.abc}, {1'b0, 1'b1, 3'd7});
        check("done20_pass", b20.pass, exp_mask == 8'h00);
        check("done20_count", b20.err_count, $countones(exp_mask));
        check("done20_mask", b20.err_mask, exp_mask);
    endtask

    task automatic sweep20(input int mode, input logic [7:0] flip, input logic [7:0] exp_mask,
                           input int inject_at);
        mode20 = mode;
        flip20 = flip;
        @(negedge clk); b20.start = 1'b1;
        @(negedge clk); b20.start = 1'b0;
        for (int c = 0; c < 8 * D20; c++) begin
            b20.start = (c == inject_at);
            check("run20", {b20.busy, b20.done, b20.abc}, {1'b1, 1'b0, 3'(c / D20)});
            @(negedge clk);
        end
        b20.start = 1'b0;
        check_done20(exp_mask);
        repeat (3) @(negedge clk);
        check_done20(exp_mask);
        $display("sweep20 mode=%0d flip=%02h mask=%02h count=%0d pass=%0d",
                 mode, flip, b20.err_mask, b20.err_count, b20.pass);
    endtask

    initial begin
        logic [7:0] f;
        b20.start = 1'b0;
        b2.start  = 1'b0;
        rst20 = 1'b1;
        rst2  = 1'b1;
        repeat (3) @(negedge clk);
        rst20 = 1'b0;
        rst2  = 1'b0;
        @(negedge clk);
        check("reset20", {b20.abc, b20.busy, b20.done, b20.pass, b20.err_count, b20.err_mask}, 32'd0);
        check("reset2", {b2.abc, b2.busy, b2.done, b2.pass, b2.err_count, b2.err_mask}, 32'd0);

        // Directed gate faults; a start pulse mid-sweep must be ignored.
        sweep20(0, 8'h00, 8'h00, 47);
        sweep20(1, 8'h00, 8'hFE, 100);
        sweep20(2, 8'h00, 8'h01, -1);
        sweep20(3, 8'h00, 8'h0E, 21);
        sweep20(5, 8'h00, 8'h20, -1);

        for (int i = 0; i < 4; i++) begin
            f = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            sweep20(4, f, ref_mask(4, f), int'($urandom_range(1, 150)));
        end

        // Asynchronous reset mid-sweep at vector 3 with errors already recorded.
        mode20 = 1;
        @(negedge clk); b20.start = 1'b1;
        @(negedge clk); b20.start = 1'b0;
        repeat (65) @(negedge clk);
        check("pre_rst_abc", b20.abc, 3'd3);
        check("pre_rst_count", b20.err_count, 4'd2);
        @(posedge clk);
        #2 rst20 = 1'b1;
        #1 check("async_rst", {b20.abc, b20.busy, b20.done, b20.pass, b20.err_count, b20.err_mask}, 32'd0);
        $display("async reset abc=%0d busy=%0b count=%0d", b20.abc, b20.busy, b20.err_count);
        @(negedge clk); rst20 = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {b20.abc, b20.busy, b20.done}, 5'd0);
        sweep20(0, 8'h00, 8'h00, -1);

        // DWELL=2: single sweep with an injected pulse, then start held high.
        mode2 = 4;
        flip2 = 8'($urandom);
        @(negedge clk); b2.start = 1'b1;
        @(negedge clk); b2.start = 1'b0;
        for (int c = 0; c < 16; c++) begin
            b2.start = (c == 7);
            check("run2", {b2.busy, b2.done, b2.abc}, {1'b1, 1'b0, 3'(c / D2)});
            @(negedge clk);
        end
        b2.start = 1'b0;
        check("done2_flags", {b2.busy, b2.done, b2.abc}, {1'b0, 1'b1, 3'd7});
        check("done2_mask", b2.err_mask, ref_mask(4, flip2));
        $display("sweep2 single flip=%02h mask=%02h pass=%0d", flip2, b2.err_mask, b2.pass);

        @(negedge clk); b2.start = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 17 * 3; c++) begin
            if (c % 17 == 16) begin
                check("b2b_done", {b2.busy, b2.done, b2.abc}, {1'b0, 1'b1, 3'd7});
                check("b2b_mask", b2.err_mask, ref_mask(4, flip2));
                check("b2b_count", b2.err_count, $countones(ref_mask(4, flip2)));
                check("b2b_pass", b2.pass, flip2 == 8'h00);
                $display("sweep2 back-to-back %0d mask=%02h pass=%0d", c / 17, b2.err_mask, b2.pass);
            end else begin
                check("b2b_run", {b2.busy, b2.done, b2.abc}, {1'b1, 1'b0, 3'((c % 17) / D2)});
            end
            @(negedge clk);
        end
        b2.start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/or3_vector_sequencer.md
Name: or3_vector_sequencer

Overview:
- Synthesizable stimulus-and-check stage for the week's three-input OR gate.
- Sits on both sides of the gate:
  - Upstream, it drives a, b and c through all 8 input combinations. Each combination is held for a programmable dwell time.
  - Downstream, it samples the gate output d at the end of each dwell and compares it with the expected OR.
- Lets a board run the exhaustive OR check without a simulator. Reports pass/fail and a per-vector error mask for LEDs.

Parameters:
- DWELL, 20: clock cycles each vector is held. Legal range 2..65535. Elaboration fails outside this range.
- CNT_W, 16: width of the dwell counter. Must satisfy 2**CNT_W >= DWELL.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  level-sampled request to begin a sweep
- abc  output  3  drive to the gate: abc[2]=a, abc[1]=b, abc[0]=c
- d  input  1  gate output under test
- busy  output  1  high while a sweep is in progress
- done  output  1  high once a sweep completes; held until the next start or reset
- pass  output  1  valid only when done=1; high iff no mismatch occurred
- err_count  output  4  number of mismatching vectors, 0..8
- err_mask  output  8  bit k set iff vector k (abc==k) mismatched

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All state is in a single clk domain.
- Reset values: state=IDLE, abc=3'b000, busy=0, done=0, pass=0, err_count=0, err_mask=8'h00, internal vector index and dwell counter = 0.
- All outputs are registered. d is used directly, with no synchronizer, because it comes from same-clock combinational logic.

State machine:
- IDLE:
  - abc=0, busy=0, done=0.
  - start=1 at an edge moves to RUN at that edge: vec=0, cnt=0, abc=0, err_count and err_mask cleared, busy=1.
- RUN:
  - abc=vec. cnt increments every cycle.
  - When cnt==DWELL-1:
    - d is sampled and compared with expected = |vec.
    - On mismatch, err_mask[vec] is set and err_count is incremented.
  - At that same edge:
    - If vec<7: vec increments and cnt returns to 0. abc changes on the same edge.
    - If vec==7: go to DONE.
  - The gate therefore sees each vector for exactly DWELL cycles. d is sampled DWELL-1 cycles after the vector is applied.
- DONE:
  - busy=0, done=1, pass=(err_count==0 including the final vector). abc holds 3'b111. err_count and err_mask are held.
  - start=1 restarts a sweep exactly as from IDLE, and done drops on that edge.

Timing:
- start is sampled at edge N.
- done rises at edge N+8*DWELL.
- busy is high for exactly 8*DWELL cycles.

Boundary conditions:
- start while RUN is ignored: no restart and no counter disturbance.
- start held high continuously gives back-to-back sweeps. done is high for exactly one cycle between sweeps, and err_* show the previous sweep during that cycle.
- rst mid-sweep asynchronously returns every output to its reset value. No partial result is kept.
- err_count saturation cannot occur, since the maximum is 8 and the field is 4 bits. There is still no wrap logic.
- d=X/Z at a sample edge is treated as a mismatch: the comparison is written as a case-inequality-safe check against expected.
- vec is 3 bits. The transition to DONE is taken explicitly at vec==7; vec is never allowed to wrap to 0.

Decomposition:
- Shared package or3_lab_pkg holds:
  - the state enum {IDLE, RUN, DONE}
  - NUM_VECTORS=8
  - the function expected_or3(vec) returning |vec
- A later AND/XOR lab reuses the sequencer by swapping only that function.
- One natural sub-module is dwell_timer (parameters DWELL, CNT_W):
  - inputs: clk, rst, clear, enable
  - output: last, asserted when cnt==DWELL-1
- The top-level FSM consumes last.

Test Plan:
- Correct OR model, DWELL=20, start pulse at cycle 5:
  - abc steps 0..7 every 20 cycles.
  - done rises at cycle 165, pass=1, err_count=0, err_mask=8'h00.
- d stuck at 0: done with pass=0, err_count=7, err_mask=8'hFE.
- d stuck at 1: pass=0, err_count=1, err_mask=8'h01.
- d = a only (abc[2]): vectors 1, 2 and 3 mismatch, giving err_count=3, err_mask=8'h0E.
- rst asserted at cycle 70 with DWELL=20 (vec=3 in RUN):
  - All outputs go to zero immediately, state is IDLE.
  - A new start completes a clean sweep with pass=1.
- DWELL=2, start held high continuously, plus a start pulse injected mid-sweep:
  - The injected pulse has no effect.
  - done is high for 1 cycle every 17 cycles.
  - Each sweep lasts exactly 16 busy cycles.
